// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state type and default latencies for the multiply/divide unit.
// Keep op code values in step with the instruction decoder in the control block.
package muldiv_unit_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_calc.sv
// Combinational result generator: full HI/LO image for any op given current HI/LO.
// Zero latency; res_valid=0 marks ops that must be treated as not started.
module muldiv_calc
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_valid
);

  logic [2*WIDTH-1:0] s_prod;
  logic [2*WIDTH-1:0] u_prod;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] res;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Truncating modulo-2^(2W) products give exact low halves for both signednesses.
  assign s_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign acc    = {hi, lo};

  // Sign-magnitude divide: most-negative / -1 falls out as most-negative with zero remainder.
  assign a_neg   = (op == MD_DIV) && a[WIDTH-1];
  assign b_neg   = (op == MD_DIV) && b[WIDTH-1];
  assign mag_a   = a_neg ? -a : a;
  assign mag_b   = b_neg ? -b : b;
  assign divisor = (b == '0) ? WIDTH'(1) : mag_b;
  assign q_mag   = mag_a / divisor;
  assign r_mag   = mag_a % divisor;
  assign quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    res       = acc;
    res_valid = 1'b1;
    case (op)
      MD_MULT:  res = s_prod;
      MD_MULTU: res = u_prod;
      MD_DIV, MD_DIVU: begin
        if (b != '0) res = {rem, quo};
      end
      MD_MTHI:  res = {a, lo};
      MD_MTLO:  res = {hi, a};
      MD_MADD:  begin res = acc + s_prod; res_valid = ACC_EN; end
      MD_MADDU: begin res = acc + u_prod; res_valid = ACC_EN; end
      MD_MSUB:  begin res = acc - s_prod; res_valid = ACC_EN; end
      MD_MSUBU: begin res = acc - u_prod; res_valid = ACC_EN; end
      default:  res_valid = 1'b0;
    endcase
  end

  assign res_hi = res[2*WIDTH-1:WIDTH];
  assign res_lo = res[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mul/div with architectural HI/LO; result commits LAT cycles after accept with a done pulse.
// No backpressure: ops issued while busy or with cancel are dropped; stall logic must hold them off.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter bit ACC_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
  logic [WIDTH-1:0] sh_lo_q, sh_lo_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_valid;
  logic             accept;
  logic             is_mt;
  logic             is_div;

  muldiv_calc #(
    .WIDTH  (WIDTH),
    .ACC_EN (ACC_EN)
  ) u_calc (
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi_q),
    .lo        (lo_q),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  assign is_mt  = (op == MD_MTHI) || (op == MD_MTLO);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign accept = start && !cancel && (state_q == ST_IDLE) && res_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mt) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end else begin
            sh_hi_d = res_hi;
            sh_lo_d = res_lo;
            cnt_d   = is_div ? DIV_CNT : MULT_CNT;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
